// File: rtl/priority_arbiter.sv
// Purpose: shares one resource among 8 requesters, fixed-priority or round-robin, with a hold limit per ownership.
// Latency: one cycle from req to registered gnt; one cycle from done/req-drop/en-low to release; one IDLE cycle between owners.
// Backpressure: none; requesters hold req until granted, and non-owner requests are ignored while a grant is active.

// Combinational priority encoder: highest set index wins.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       any
);

  // Scan low to high so the last (highest) set bit overrides earlier hits.
  always_comb begin
    idx = 3'd0;
    any = |req;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

module priority_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       mode,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state, state_d;
  logic [2:0] ptr, ptr_d;
  logic [7:0] cnt, cnt_d;
  logic [7:0] gnt_d;
  logic [2:0] gnt_id_d;
  logic       gnt_valid_d;
  logic       timeout_d;

  logic [7:0] rot_req;
  logic [7:0] sel_req;
  logic [2:0] enc_idx;
  logic       enc_any;
  logic [2:0] winner;
  logic       owner_req;
  logic       at_limit;
  logic       release_now;

  // Rotate requests so that ptr-1 lands on the top bit and ptr itself on bit 0;
  // the shared highest-wins encoder then yields the round-robin search order.
  always_comb begin
    rot_req = 8'd0;
    for (int j = 0; j < 8; j++) begin
      rot_req[j] = req[3'(ptr + 3'(j))];
    end
  end

  assign sel_req = mode ? rot_req : req;

  prio_enc8 u_enc (
    .req (sel_req),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Undo the rotation (3-bit add wraps modulo 8).
  assign winner      = mode ? 3'(ptr + enc_idx) : enc_idx;
  assign owner_req   = req[gnt_id];
  assign at_limit    = (cnt == HOLD_LIM);
  assign release_now = !en || done || !owner_req || at_limit;

  // Next-state and next-output decision; every exit from GRANT passes through IDLE.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    cnt_d       = cnt;
    gnt_d       = gnt;
    gnt_id_d    = gnt_id;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;
    case (state)
      IDLE: begin
        if (en && enc_any) begin
          state_d     = GRANT;
          gnt_d       = 8'b1 << winner;
          gnt_id_d    = winner;
          gnt_valid_d = 1'b1;
          ptr_d       = winner;
          cnt_d       = 8'd1;
        end else begin
          gnt_d       = 8'd0;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          cnt_d       = 8'd0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d     = IDLE;
          gnt_d       = 8'd0;
          gnt_id_d    = 3'd0;
          gnt_valid_d = 1'b0;
          cnt_d       = 8'd0;
          // Pulse only when the hold limit alone forced the release.
          timeout_d   = en && !done && owner_req && at_limit;
        end else begin
          // Saturating increment; the limit check above normally exits first.
          cnt_d = at_limit ? cnt : cnt + 8'd1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'd0;
        gnt_id_d    = 3'd0;
        gnt_valid_d = 1'b0;
        cnt_d       = 8'd0;
      end
    endcase
  end

  // State, pointer, counter and all outputs are flops cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      cnt       <= 8'd0;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      gnt_id    <= gnt_id_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

endmodule
